// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package rf_arb_pkg;

  localparam int REG_AW = 5;
  localparam int XLEN   = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_P0,
    GNT_P1
  } grant_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending long-latency write bitmap with rs1/rs2 lookup and sticky double-set error.
module rf_scoreboard
  import rf_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_i,
  input  logic [REG_AW-1:0] set_rd_i,
  input  logic              clr_i,
  input  logic [REG_AW-1:0] clr_rd_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  output logic              rs1_busy_o,
  output logic              rs2_busy_o,
  output logic              err_o
);

  logic [31:0] busy_q, busy_d;
  logic        err_q, err_d;
  logic        set_any;

  assign set_any = set_i && (set_rd_i != '0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    if (clr_i)
      busy_d[clr_rd_i] = 1'b0;
    // Set is applied after clear so a same-cycle set of the same register wins.
    if (set_any) begin
      busy_d[set_rd_i] = 1'b1;
      if (busy_q[set_rd_i])
        err_d = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign rs1_busy_o = busy_q[rs1_i];
  assign rs2_busy_o = busy_q[rs2_i];
  assign err_o      = err_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the register file write port with a registered output stage.
// Build option RF_ARB_FAIRNESS_EN adds the wait_cnt starvation guard for port 1.
module rf_wb_arbiter #(
  parameter int XLEN     = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            p0_valid,
  input  logic [4:0]      p0_rd,
  input  logic [XLEN-1:0] p0_data,
  output logic            p0_ready,
  input  logic            p1_valid,
  input  logic [4:0]      p1_rd,
  input  logic [XLEN-1:0] p1_data,
  output logic            p1_ready,
  input  logic            sb_set,
  input  logic [4:0]      sb_rd,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            sb_err,
  output logic            rf_write,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);
  import rf_arb_pkg::*;

  logic force1;

`ifdef RF_ARB_FAIRNESS_EN
  logic [3:0] wait_q, wait_d;

  assign force1 = (wait_q == 4'(MAX_WAIT)) && p1_valid;

  always_comb begin
    wait_d = wait_q;
    if (!p1_valid || p1_ready)
      wait_d = '0;
    else if (wait_q != 4'(MAX_WAIT))
      wait_d = wait_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_q <= '0;
    else        wait_q <= wait_d;
  end
`else
  localparam int unused_max_wait = MAX_WAIT;
  assign force1 = 1'b0;
`endif

  assign p0_ready = !force1;
  assign p1_ready = force1 || !p0_valid;

  grant_e            gnt;
  logic [REG_AW-1:0] win_rd;
  logic [XLEN-1:0]   win_data;
  logic              rf_write_q, rf_write_d;
  logic [REG_AW-1:0] rf_waddr_q;
  logic [XLEN-1:0]   rf_wdata_q;

  // The ready equations already make the two transfers mutually exclusive.
  always_comb begin
    gnt      = GNT_NONE;
    win_rd   = '0;
    win_data = '0;
    if (p1_valid && p1_ready) begin
      gnt      = GNT_P1;
      win_rd   = p1_rd;
      win_data = p1_data;
    end else if (p0_valid && p0_ready) begin
      gnt      = GNT_P0;
      win_rd   = p0_rd;
      win_data = p0_data;
    end
  end

  // x0 writes complete the handshake but never reach the register file.
  assign rf_write_d = (gnt != GNT_NONE) && (win_rd != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_write_q <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_write_q <= rf_write_d;
      if (rf_write_d) begin
        rf_waddr_q <= win_rd;
        rf_wdata_q <= win_data;
      end
    end
  end

  assign rf_write = rf_write_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  rf_scoreboard u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_i      (sb_set),
    .set_rd_i   (sb_rd),
    .clr_i      (gnt == GNT_P1),
    .clr_rd_i   (p1_rd),
    .rs1_i      (rs1),
    .rs2_i      (rs2),
    .rs1_busy_o (rs1_busy),
    .rs2_busy_o (rs2_busy),
    .err_o      (sb_err)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: a reference model predicts handshakes and scoreboard
// state; expected register-file writes are queued and checked by an independent monitor.
module tb_rf_wb_arbiter;

  localparam int XLEN     = 32;
  localparam int MAX_WAIT = 4;
`ifdef RF_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            p0_valid, p1_valid, sb_set;
  logic [4:0]      p0_rd, p1_rd, sb_rd, rs1, rs2;
  logic [XLEN-1:0] p0_data, p1_data;
  logic            p0_ready, p1_ready, rs1_busy, rs2_busy, sb_err;
  logic            rf_write;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  rf_wb_arbiter #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .p0_valid (p0_valid),
    .p0_rd    (p0_rd),
    .p0_data  (p0_data),
    .p0_ready (p0_ready),
    .p1_valid (p1_valid),
    .p1_rd    (p1_rd),
    .p1_data  (p1_data),
    .p1_ready (p1_ready),
    .sb_set   (sb_set),
    .sb_rd    (sb_rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .sb_err   (sb_err),
    .rf_write (rf_write),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              due;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } exp_wr_t;

  exp_wr_t exp_q[$];
  int      errors = 0;
  int      checks = 0;
  int      cyc    = 0;

  // Reference state: set of registers with a pending long-latency write, sticky error flag,
  // and how many consecutive cycles port 1 has been kept waiting.
  bit [31:0] m_busy;
  bit        m_err;
  int        streak;
  bit        p0_done, p1_done, seen_p1r;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = '0;
    m_err  = 1'b0;
    streak = 0;
    exp_q.delete();
  endtask

  // One clock: compare combinational outputs mid-cycle, predict this edge, advance.
  task automatic step();
    bit forced, e_p0r, e_p1r, x0, x1;
    @(negedge clk);
    forced = FAIR && (streak >= MAX_WAIT) && p1_valid;
    e_p0r  = !forced;
    e_p1r  = forced || !p0_valid;
    check("p0_ready", p0_ready, e_p0r);
    check("p1_ready", p1_ready, e_p1r);
    check("rs1_busy", rs1_busy, m_busy[rs1]);
    check("rs2_busy", rs2_busy, m_busy[rs2]);
    check("sb_err", sb_err, m_err);
    seen_p1r = p1_ready;
    x0 = p0_valid && e_p0r;
    x1 = p1_valid && e_p1r;
    if (x1 && p1_rd != 0)      exp_q.push_back('{cyc + 1, p1_rd, p1_data});
    else if (x0 && p0_rd != 0) exp_q.push_back('{cyc + 1, p0_rd, p0_data});
    if (sb_set && sb_rd != 0 && m_busy[sb_rd]) m_err = 1'b1;
    if (x1) m_busy[p1_rd] = 1'b0;
    if (sb_set && sb_rd != 0) m_busy[sb_rd] = 1'b1;
    if (p1_valid && !e_p1r) streak = (streak < MAX_WAIT) ? streak + 1 : MAX_WAIT;
    else                    streak = 0;
    p0_done = x0;
    p1_done = x1;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Monitor: every register-file write must match the oldest expected write, on time.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rf_write) begin
        if (exp_q.size() == 0) begin
          check("rf_write_unexpected", 1, 0);
        end else begin
          exp_wr_t e;
          e = exp_q.pop_front();
          check("rf_write_cycle", cyc, e.due);
          check("rf_waddr", rf_waddr, e.rd);
          check("rf_wdata", rf_wdata, e.data);
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        check("rf_write_missing", 0, 1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic drive_random();
    if (!p0_valid || p0_done) begin
      p0_valid = 1'($urandom_range(0, 1));
      p0_rd    = 5'($urandom_range(0, 7));
      p0_data  = $urandom;
    end
    if (!p1_valid || p1_done) begin
      p1_valid = ($urandom_range(0, 2) == 0);
      p1_rd    = 5'($urandom_range(0, 7));
      p1_data  = $urandom;
    end
    sb_set = ($urandom_range(0, 3) == 0);
    sb_rd  = 5'($urandom_range(0, 7));
    rs1    = 5'($urandom_range(0, 7));
    rs2    = 5'($urandom_range(0, 7));
  endtask

  initial begin
    int  refusals;
    bit  p1_ever;
    rst_n = 1'b0;
    {p0_valid, p1_valid, sb_set} = '0;
    {p0_rd, p1_rd, sb_rd, rs1, rs2} = '0;
    p0_data = '0;
    p1_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rf_write", rf_write, 0);
    check("reset_rf_waddr", rf_waddr, 0);
    check("reset_rf_wdata", rf_wdata, 0);
    rst_n = 1'b1;
    step();

    // Port 0 write to x5; monitor expects it one cycle later and nothing after.
    p0_valid = 1'b1; p0_rd = 5'd5; p0_data = 32'hDEADBEEF;
    step();
    p0_valid = 1'b0;
    repeat (2) step();

    // Pending write on x7 cleared by a port 1 transfer.
    sb_set = 1'b1; sb_rd = 5'd7; rs1 = 5'd7;
    step();
    sb_set = 1'b0;
    p1_valid = 1'b1; p1_rd = 5'd7; p1_data = 32'h1234;
    step();
    p1_valid = 1'b0;
    repeat (2) step();

    // Continuous port 0 traffic against a waiting port 1.
    p0_valid = 1'b1; p0_rd = 5'd1;
    p1_valid = 1'b1; p1_rd = 5'd2; p1_data = 32'hCAFE0002;
    refusals = 0;
    p1_ever  = 1'b0;
    for (int i = 0; i < 10 && !p1_ever; i++) begin
      p0_data = $urandom;
      step();
      if (seen_p1r) p1_ever = 1'b1;
      else          refusals++;
    end
`ifdef RF_ARB_FAIRNESS_EN
    check("p1_forced_through", p1_ever, 1);
    check("p1_refusals", refusals, MAX_WAIT);
`else
    check("p1_starved", p1_ever, 0);
`endif
    p0_valid = 1'b0; p1_valid = 1'b0;
    step();

    // Port 1 write to x0: handshake completes, no register-file write.
    p1_valid = 1'b1; p1_rd = 5'd0; p1_data = 32'h5555AAAA;
    step();
    p1_valid = 1'b0;
    repeat (2) step();

    // Double set of x9 raises the sticky error.
    sb_set = 1'b1; sb_rd = 5'd9; rs2 = 5'd9;
    repeat (2) step();
    sb_set = 1'b0;
    repeat (2) step();

    // Same-cycle set and clear of x3: set wins.
    sb_set = 1'b1; sb_rd = 5'd3; rs1 = 5'd3;
    p1_valid = 1'b1; p1_rd = 5'd3; p1_data = 32'h33;
    step();
    sb_set = 1'b0; p1_valid = 1'b0;
    repeat (2) step();

    // Randomized traffic.
    p0_done = 1'b0; p1_done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      drive_random();
      step();
    end

    // Reset in the middle of traffic: output stage and busy bits drop immediately.
    p0_valid = 1'b0; p1_valid = 1'b0;
    sb_set = 1'b1; sb_rd = 5'd12; rs1 = 5'd12;
    step();
    sb_set = 1'b0;
    p0_valid = 1'b1; p0_rd = 5'd5; p0_data = 32'h0BADF00D;
    step();
    rst_n = 1'b0;
    #1;
    check("midreset_rf_write", rf_write, 0);
    check("midreset_rs1_busy", rs1_busy, 0);
    check("midreset_sb_err", sb_err, 0);
    model_reset();
    p0_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();

    p0_done = 1'b0; p1_done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      drive_random();
      step();
    end
    p0_valid = 1'b0; p1_valid = 1'b0; sb_set = 1'b0;
    repeat (3) step();
    check("writes_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and pending-write scoreboard in front of the 32x32 register file's single write port. It shares that port between the in-order pipeline write-back (port 0) and a long-latency unit such as load-miss or divide (port 1), and drives the register file's write enable, address and data from a registered output stage. It also tracks destination registers with an outstanding long-latency write, so the issue logic can stall dependent reads.

## Interface
Parameters:
- XLEN, 32, data width
- MAX_WAIT, 4, consecutive cycles port 1 may be refused before it is forced through (range 1..15)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- p0_valid  in  1  pipeline write-back request
- p0_rd  in  5  port 0 destination
- p0_data  in  XLEN  port 0 data
- p0_ready  out  1  port 0 accepted this cycle (combinational)
- p1_valid  in  1  long-latency unit request
- p1_rd  in  5  port 1 destination
- p1_data  in  XLEN  port 1 data
- p1_ready  out  1  port 1 accepted this cycle (combinational)
- sb_set  in  1  issue stage dispatched a long-latency op
- sb_rd  in  5  its destination
- rs1, rs2  in  5  source registers being decoded
- rs1_busy, rs2_busy  out  1  source has a pending long-latency write (combinational)
- sb_err  out  1  sticky; set when sb_set targets an already-busy register
- rf_write  out  1  register-file write enable (registered)
- rf_waddr  out  5  register-file write address (registered)
- rf_wdata  out  XLEN  register-file write data (registered)

## Operation
- Handshake: a transfer occurs on port N when pN_valid && pN_ready at posedge. Requesters hold rd and data stable until the transfer.
- force1 = (wait_cnt == MAX_WAIT) && p1_valid.
- p0_ready = !force1.
- p1_ready = force1 || !p0_valid.
- Only one port transfers per cycle.
- wait_cnt (4 bits):
  - Increments when p1_valid && !p1_ready.
  - Clears on any port 1 transfer or when p1_valid is low.
  - Saturates at MAX_WAIT.
- Output stage, registered every cycle:
  - rf_write <= (transfer on either port) && (winner rd != 0).
  - rf_waddr and rf_wdata take the winner's rd and data when rf_write is set; otherwise they hold their previous values.
- x0 writes: the handshake completes (ready asserted, scoreboard updated), but no rf_write is issued.
- Scoreboard: busy[31:1] bitmap; busy[0] is constantly 0.
  - sb_set with sb_rd != 0 sets busy[sb_rd].
  - A port 1 transfer clears busy[p1_rd].
  - Set and clear of the same rd in the same cycle: set wins.
  - Setting a register whose busy bit is already 1 sets sb_err. sb_err clears only on reset.
- rsN_busy = busy[rsN], read from the registered bitmap. A port 1 transfer in the current cycle does not drop busy until the next cycle.
- Port 0 never touches the scoreboard.

## Timing
- Reset values: rf_write=0, rf_waddr=0, rf_wdata=0, busy=0, wait_cnt=0, sb_err=0. Combinational outputs follow from these values.
- Latency: handshake at edge T gives rf_write high during cycle T+1, and the register file commits at edge T+1. The register file's read bypass covers the cycle in which rf_write is high.
- Worst-case port 1 wait under continuous port 0 traffic: MAX_WAIT cycles refused, then accepted on the next cycle.
- During a forced cycle, port 0 stalls exactly one cycle.
- Reset mid-operation:
  - In-flight output-stage writes are discarded.
  - All busy bits clear.
  - Requesters must re-present after rst_n deasserts.

## Configuration
- RF_ARB_FAIRNESS_EN defined: the wait_cnt starvation guard described above is built in.
- RF_ARB_FAIRNESS_EN undefined:
  - Strict priority to port 0; p0_ready is constantly 1 and p1_ready = !p0_valid.
  - wait_cnt is not built, and MAX_WAIT is ignored.

## Structure
- Shared package rf_arb_pkg:
  - Constants REG_AW=5 and XLEN=32.
  - Typedef wb_req_t struct with fields rd [4:0] and data [XLEN-1:0].
  - Enum grant_e with values GNT_NONE, GNT_P0, GNT_P1.
- Sub-module rf_scoreboard holds the busy bitmap, set/clear priority, the rs1/rs2 lookup and sb_err. The arbiter and output stage stay in the top module.

## Test plan
- Reset with all inputs idle -> rf_write=0, p0_ready=1, p1_ready=1, rs1_busy=0, sb_err=0.
- p0 writes x5=0xDEADBEEF at edge T -> rf_write=1, rf_waddr=5, rf_wdata=0xDEADBEEF during cycle T+1; rf_write=0 in cycle T+2.
- sb_set rd=7; then p1 writes x7=0x1234 -> rs1=7 reads busy=1 until the cycle after the p1 transfer, then 0; rf_waddr=7.
- p0_valid held high and p1_valid held high with MAX_WAIT=4 (fairness on) -> p1 refused for 4 cycles, then accepted in cycle 5 with p0_ready=0 for that one cycle. With the macro off, p1 is never accepted.
- p1 write to x0 -> p1_ready=1, rf_write stays 0. sb_set rd=9 twice without a clear -> sb_err=1 and it remains 1.
- sb_set rd=3 in the same cycle as a p1 transfer to x3 -> busy[3]=1 afterward. rst_n pulse low mid-stream -> busy=0 and rf_write=0 immediately.
